// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS-lite multicycle controller.
// Used by mc_aludec and mips_mc_ctrl.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPE,
    ALUWB,
    BEQ,
    ADDI,
    ORI,
    IWB,
    JUMP,
    ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       imm_ext;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       aluen;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU-control decoder.
// aluop selects add, sub, or, or a funct-driven operation.
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_OR:  alucontrol = ALU_OR;
      default: begin
        unique case (1'b1)
          (funct == F_ADD): alucontrol = ALU_ADD;
          (funct == F_SUB): alucontrol = ALU_SUB;
          (funct == F_AND): alucontrol = ALU_AND;
          (funct == F_OR):  alucontrol = ALU_OR;
          (funct == F_SLT): alucontrol = ALU_SLT;
          default:          alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS-lite control sequencer with memory-ready handshake.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       imm_ext,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  localparam int CW =
    (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_t        state;
  state_t        state_n;
  ctrl_t         c;
  logic [CW-1:0] cnt;
  logic [2:0]    dec_alu;
  logic          timeout;

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:  if (mem_ready) state_n = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    state_n = MEMADR;
          (op == OP_RTYPE): state_n = RTYPE;
          (op == OP_BEQ):   state_n = BEQ;
          (op == OP_ADDI):  state_n = ADDI;
          (op == OP_ORI):   state_n = ORI;
          (op == OP_J):     state_n = JUMP;
          default:          state_n = ILLEGAL;
        endcase
      end
      MEMADR: state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_n = MEMWB;
      MEMWB:  state_n = FETCH;
      MEMWR:  if (mem_ready) state_n = FETCH;
      RTYPE:  state_n = ALUWB;
      ALUWB:  state_n = FETCH;
      BEQ:    state_n = FETCH;
      ADDI:   state_n = IWB;
      ORI:    state_n = IWB;
      IWB:    state_n = FETCH;
      JUMP:   state_n = FETCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      ILLEGAL: state_n = ILLEGAL;
`else
      ILLEGAL: state_n = FETCH;
`endif
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluen   = 1'b1;
        c.aluop   = AOP_ADD;
        c.pcsrc   = PC_ALU;
        c.irwrite = mem_ready;
        c.pcwrite = mem_ready;
      end
      DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluen   = 1'b1;
        c.aluop   = AOP_ADD;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluen   = 1'b1;
        c.aluop   = AOP_ADD;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      RTYPE: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluen   = 1'b1;
        c.aluop   = AOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQ: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_RT;
        c.aluen   = 1'b1;
        c.aluop   = AOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
      end
      ADDI: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluen   = 1'b1;
        c.aluop   = AOP_ADD;
      end
      ORI: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.imm_ext = 1'b1;
        c.aluen   = 1'b1;
        c.aluop   = AOP_OR;
      end
      IWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = PC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
  end

  mc_aludec u_aludec (
    .aluop      (c.aluop),
    .funct      (funct),
    .alucontrol (dec_alu)
  );

  // Counter only advances while a requested access is stalled.
  assign timeout = (MEM_WAIT_MAX != 0) && c.mem_req &&
                   (cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (MEM_WAIT_MAX == 0 || !c.mem_req ||
             mem_ready || timeout)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!reset)
      illegal_q <= 1'b0;
    else if (state_n == ILLEGAL)
      illegal_q <= 1'b1;
  end

  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign mem_req     = c.mem_req;
  assign iord        = c.iord;
  assign memwrite    = c.memwrite;
  assign irwrite     = c.irwrite;
  assign regdst      = c.regdst;
  assign memtoreg    = c.memtoreg;
  assign regwrite    = c.regwrite;
  assign alusrca     = c.alusrca;
  assign alusrcb     = c.alusrcb;
  assign imm_ext     = c.imm_ext;
  assign pcsrc       = c.pcsrc;
  assign pcen        = c.pcwrite | (c.branch & zero);
  assign alucontrol  = c.aluen ? dec_alu : 3'b000;
  assign mem_timeout = timeout;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl.
// Builds with or without MIPS_CTRL_ILLEGAL_TRAP_EN.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       imm_ext;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       mem_timeout;
  logic       illegal_instr;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .iord          (iord),
    .memwrite      (memwrite),
    .irwrite       (irwrite),
    .regdst        (regdst),
    .memtoreg      (memtoreg),
    .regwrite      (regwrite),
    .alusrca       (alusrca),
    .alusrcb       (alusrcb),
    .imm_ext       (imm_ext),
    .pcsrc         (pcsrc),
    .pcen          (pcen),
    .alucontrol    (alucontrol),
    .mem_timeout   (mem_timeout),
    .illegal_instr (illegal_instr)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] al_tab [6];

  initial begin
    fn_tab[0] = 6'b100000; al_tab[0] = 3'b010;
    fn_tab[1] = 6'b100010; al_tab[1] = 3'b110;
    fn_tab[2] = 6'b100100; al_tab[2] = 3'b000;
    fn_tab[3] = 6'b100101; al_tab[3] = 3'b001;
    fn_tab[4] = 6'b101010; al_tab[4] = 3'b111;
    fn_tab[5] = 6'b111111; al_tab[5] = 3'b010;

    reset = 1'b0; op = 6'b0; funct = 6'b0;
    zero = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_mem_req", 8'(mem_req), 8'h1);
    chk("rst_irwrite", 8'(irwrite), 8'h0);
    chk("rst_pcen", 8'(pcen), 8'h0);
    chk("rst_illegal", 8'(illegal_instr), 8'h0);
    chk("rst_alusrcb", 8'(alusrcb), 8'h1);

    // lw with memory always ready
    reset = 1'b1; op = 6'b100011; mem_ready = 1'b1;
    #1;
    chk("lw1_pcen", 8'(pcen), 8'h1);
    chk("lw1_irwrite", 8'(irwrite), 8'h1);
    chk("lw1_regwrite", 8'(regwrite), 8'h0);
    tick();
    chk("lw2_alusrcb", 8'(alusrcb), 8'h3);
    chk("lw2_pcen", 8'(pcen), 8'h0);
    chk("lw2_mem_req", 8'(mem_req), 8'h0);
    tick();
    chk("lw3_srca", 8'(alusrca), 8'h1);
    chk("lw3_srcb", 8'(alusrcb), 8'h2);
    chk("lw3_alu", 8'(alucontrol), 8'h2);
    tick();
    chk("lw4_req_iord", {mem_req, iord}, 8'h3);
    chk("lw4_regwrite", 8'(regwrite), 8'h0);
    tick();
    chk("lw5_wb", {regwrite, memtoreg, regdst}, 8'h6);
    chk("lw5_pcen", 8'(pcen), 8'h0);
    tick();
    chk("lw6_fetch", {mem_req, iord, regwrite}, 8'h4);

    // sw with three stalled cycles
    op = 6'b101011;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_wait_memwrite", 8'(memwrite), 8'h1);
      chk("sw_wait_iord", 8'(iord), 8'h1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_last_memwrite", 8'(memwrite), 8'h1);
    tick();
    chk("sw_exit_fetch", {mem_req, iord, memwrite}, 8'h4);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick();
    chk("beq_dec_pcen", 8'(pcen), 8'h0);
    tick();
    chk("beq_t_pcen", 8'(pcen), 8'h1);
    chk("beq_t_pcsrc", 8'(pcsrc), 8'h1);
    chk("beq_t_alu", 8'(alucontrol), 8'h6);
    tick();
    zero = 1'b0;
    tick();
    tick();
    chk("beq_n_pcen", 8'(pcen), 8'h0);
    chk("beq_n_pcsrc", 8'(pcsrc), 8'h1);
    tick();

    // R-type funct table
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      tick();
      tick();
      chk("rt_alu", 8'(alucontrol), 8'(al_tab[i]));
      chk("rt_srcab", {alusrca, alusrcb}, 8'h4);
      tick();
      chk("rt_wb", {regdst, regwrite, memtoreg}, 8'h6);
      chk("rt_wb_alu", 8'(alucontrol), 8'h0);
      tick();
    end

    // ori then addi then jump
    op = 6'b001101;
    tick();
    tick();
    chk("ori_immext", 8'(imm_ext), 8'h1);
    chk("ori_alu", 8'(alucontrol), 8'h1);
    chk("ori_srcb", 8'(alusrcb), 8'h2);
    tick();
    chk("ori_wb", {regwrite, regdst, memtoreg, imm_ext}, 8'h8);
    tick();
    op = 6'b001000;
    tick();
    tick();
    chk("addi_immext", 8'(imm_ext), 8'h0);
    chk("addi_alu", 8'(alucontrol), 8'h2);
    tick();
    chk("addi_wb", 8'(regwrite), 8'h1);
    tick();
    op = 6'b000010;
    tick();
    tick();
    chk("j_pcen", 8'(pcen), 8'h1);
    chk("j_pcsrc", 8'(pcsrc), 8'h2);
    tick();

    // fetch stall: pulse after 15 counted wait cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("to_pulse", 8'(mem_timeout), 8'((i == 15) ? 1 : 0));
      chk("to_irwrite", 8'(irwrite), 8'h0);
      chk("to_hold", 8'(mem_req), 8'h1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("to_release", 8'(irwrite), 8'h1);

    // illegal opcode
    op = 6'b111111;
    tick();
    tick();
    chk("ill_strobes", {mem_req, regwrite, pcen}, 8'h0);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    chk("ill_flag", 8'(illegal_instr), 8'h1);
    tick();
    tick();
    chk("ill_stuck", {mem_req, pcen}, 8'h0);
    chk("ill_sticky", 8'(illegal_instr), 8'h1);
`else
    chk("ill_flag", 8'(illegal_instr), 8'h0);
    tick();
    chk("ill_back_fetch", 8'(mem_req), 8'h1);
`endif
    reset = 1'b0; mem_ready = 1'b0;
    tick();
    chk("ill_rst_fetch", {mem_req, iord}, 8'h2);
    chk("ill_rst_flag", 8'(illegal_instr), 8'h0);
    reset = 1'b1;

    // reset while a load is stalled
    op = 6'b100011; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("mrd_stall", {mem_req, iord}, 8'h3);
    reset = 1'b0;
    tick();
    chk("mrd_rst", {mem_req, iord, regwrite}, 8'h4);
    chk("mrd_rst_irw", 8'(irwrite), 8'h0);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("mrd_fetch_irw", 8'(irwrite), 8'h1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
